// File: rtl/vid_fetch.sv
// Line fetcher: reads line_len bytes from video memory into a small buffer and streams them out.
// First pixel appears 2 cycles after the first read; reads stall so buffered + in-flight never exceeds FIFO_DEPTH.
module vid_fetch #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-1:0] line_len,
  output logic                     mem_rd,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_din,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]            DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] ONE_A   = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_cnt, issue_cnt, accept_cnt;
  logic                     rd_pend;
  logic [DATA_WIDTH-1:0]    buf_mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, occ;
  logic                     done_q;
  logic                     issue, xfer, last_accept, launch, empty_line;

  assign pix_valid   = (count != '0);
  assign xfer        = pix_valid && pix_ready;
  assign last_accept = xfer && (accept_cnt == ONE_A);
  assign occ         = count + CW'(rd_pend);
  assign launch      = (state == IDLE) && start && (line_len != '0);
  assign empty_line  = (state == IDLE) && start && (line_len == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = FETCH;
      FETCH:   if (issue && issue_cnt == ONE_A) state_nxt = DRAIN;
      DRAIN:   if (last_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue    = 1'b0;
    underrun = 1'b0;
    busy     = (state != IDLE);
    if (state == FETCH) begin
      issue    = (issue_cnt != '0) && (occ < DEPTH_C);
      underrun = pix_ready && !pix_valid;
    end
  end

  assign mem_rd   = issue;
  assign mem_addr = addr_cnt;
  assign done     = done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_cnt   <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      rd_pend    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done_q     <= 1'b0;
    end else begin
      if (launch) begin
        addr_cnt   <= base_addr;
        issue_cnt  <= line_len;
        accept_cnt <= line_len;
      end else begin
        if (issue) begin
          addr_cnt  <= addr_cnt + ONE_A;
          issue_cnt <= issue_cnt - ONE_A;
        end
        if (xfer) accept_cnt <= accept_cnt - ONE_A;
      end
      // Memory returns data one cycle after the strobe; rd_pend marks that slot.
      rd_pend <= issue;
      if (rd_pend) wr_ptr <= wr_ptr + PW'(1);
      if (xfer)    rd_ptr <= rd_ptr + PW'(1);
      case ({rd_pend, xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      done_q <= empty_line || ((state == DRAIN) && last_accept);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_pend) buf_mem[wr_ptr] <= mem_din;
  end

  assign pix_data = pix_valid ? buf_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_vid_fetch.sv
// Directed bench for vid_fetch: memory model returns addr[7:0], a negedge monitor records
// reads, transfers and pulses, and a check task compares them against hand-computed values.
module tb_vid_fetch;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr, line_len;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid, pix_ready, busy, done, underrun;

  vid_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .line_len(line_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // memory[n] = n[7:0], registered read
  always @(posedge clk) if (mem_rd) mem_din <= mem_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] rd_q[$];
  int            rd_cyc_q[$];
  logic [DW-1:0] px_q[$];
  int  done_cnt = 0, under_cnt = 0, under_bad = 0, occ_bad = 0, first_pv = -1;
  bit  busy_seen = 0;
  bit  clr_req = 0;
  int  cur_len = 0;

  always @(negedge clk) begin
    if (clr_req) begin
      rd_q.delete(); rd_cyc_q.delete(); px_q.delete();
      done_cnt = 0; under_cnt = 0; first_pv = -1; busy_seen = 0;
    end else begin
      // Still fetching while fewer reads than the line length have been seen.
      if (underrun !== (busy && (rd_q.size() < cur_len) && pix_ready && !pix_valid)) under_bad++;
      if (underrun) under_cnt++;
      if (mem_rd && (rd_q.size() - px_q.size() >= DEPTH)) occ_bad++;
      if (mem_rd) begin rd_q.push_back(mem_addr); rd_cyc_q.push_back(cyc); end
      if (pix_valid && pix_ready) px_q.push_back(pix_data);
      if (pix_valid && first_pv < 0) first_pv = cyc;
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    clr_req = 1; step(1); clr_req = 0;
  endtask

  task automatic start_line(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(posedge clk); #1;
    start = 1; base_addr = b; line_len = l; cur_len = int'(l);
    @(posedge clk); #1;
    start = 0; base_addr = 14'h1555; line_len = 14'h02AA;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    check({tag, "_done_seen"}, 32'(ok), 1);
    if (ok) check({tag, "_busy_at_done"}, 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    resetn = 0; start = 0; base_addr = '0; line_len = '0; pix_ready = 1;
    #3;
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_busy_done_under", {29'd0, busy, done, underrun}, 0);
    step(3); resetn = 1; step(1);
    clear_mon();

    // basic 3-byte line
    start_line(14'h0100, 14'd3);
    run_until_done("t1", 40);
    step(3);
    check("t1_nreads", rd_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t1_addr%0d", i), 32'(rd_q[i]), 32'h100 + i);
    check("t1_consecutive", rd_cyc_q[2] - rd_cyc_q[0], 2);
    check("t1_npix", px_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t1_pix%0d", i), 32'(px_q[i]), i);
    check("t1_first_valid_lat", first_pv - rd_cyc_q[0], 2);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_underrun_seen", 32'(under_cnt > 0), 1);

    // backpressure: buffer fills, reads stop
    clear_mon();
    pix_ready = 0;
    start_line(14'h0010, 14'd10);
    step(10);
    check("t2_reads_stalled", rd_q.size(), 4);
    check("t2_mem_rd_low", 32'(mem_rd), 0);
    check("t2_valid_held", 32'(pix_valid), 1);
    step(1);
    check("t2_data_held", 32'(pix_data), 32'h10);
    pix_ready = 1;
    run_until_done("t2", 60);
    step(3);
    check("t2_npix", px_q.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("t2_pix%0d", i), 32'(px_q[i]), 32'h10 + i);
    check("t2_done_cnt", done_cnt, 1);

    // address wrap
    clear_mon();
    start_line(14'h3FFE, 14'd4);
    run_until_done("t3", 40);
    step(2);
    check("t3_addr0", 32'(rd_q[0]), 32'h3FFE);
    check("t3_addr1", 32'(rd_q[1]), 32'h3FFF);
    check("t3_addr2", 32'(rd_q[2]), 32'h0000);
    check("t3_addr3", 32'(rd_q[3]), 32'h0001);
    check("t3_pix2", 32'(px_q[2]), 32'h00);
    check("t3_pix1", 32'(px_q[1]), 32'hFF);

    // zero-length line
    clear_mon();
    start_line(14'h0123, 14'd0);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 1);
    check("t4_busy", 32'(busy), 0);
    @(negedge clk);
    check("t4_done_width", 32'(done), 0);
    step(2);
    check("t4_no_reads", rd_q.size(), 0);
    check("t4_busy_never", 32'(busy_seen), 0);

    // reset mid-line, then a fresh short line
    clear_mon();
    begin
      bit ok = 0;
      start_line(14'h0320, 14'd8);
      for (int i = 0; i < 40; i++) begin
        step(1);
        if (px_q.size() >= 2) begin ok = 1; break; end
      end
      check("t5_two_xfers", 32'(ok), 1);
    end
    resetn = 0; cur_len = 0;
    #2;
    check("t5_async_busy", 32'(busy), 0);
    check("t5_async_valid", 32'(pix_valid), 0);
    check("t5_async_addr", 32'(mem_addr), 0);
    step(1); resetn = 1;
    clear_mon();
    start_line(14'h0200, 14'd2);
    run_until_done("t5", 30);
    step(4);
    check("t5_npix", px_q.size(), 2);
    check("t5_pix0", 32'(px_q[0]), 32'h00);
    check("t5_pix1", 32'(px_q[1]), 32'h01);
    check("t5_done_cnt", done_cnt, 1);

    // random backpressure with ignored starts
    clear_mon();
    pix_ready = 1;
    start_line(14'h0400, 14'd12);
    begin
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        if (!busy) begin start = 0; ok = 1; break; end
        pix_ready = 1'($urandom_range(0, 1));
        start     = ($urandom_range(0, 3) == 0);
        base_addr = 14'($urandom_range(0, 16383));
        line_len  = 14'($urandom_range(1, 20));
      end
      start = 0;
      check("t6_finished", 32'(ok), 1);
    end
    pix_ready = 1;
    step(3);
    check("t6_nreads", rd_q.size(), 12);
    check("t6_npix", px_q.size(), 12);
    begin
      int bad = 0;
      for (int i = 0; i < px_q.size(); i++) if (px_q[i] !== 8'(i)) bad++;
      check("t6_pix_order", bad, 0);
    end
    check("t6_done_cnt", done_cnt, 1);
    check("t6_underrun_seen", 32'(under_cnt > 0), 1);

    check("all_underrun_rule", under_bad, 0);
    check("all_occupancy_rule", occ_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vid_fetch.md
VID_FETCH -- requirements
Module: vid_fetch

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 14: width of the video memory address.
REQ-002 Parameter DATA_WIDTH, default 8: width of a video memory byte and of a pixel-stream word.
REQ-003 Parameter FIFO_DEPTH, default 4: number of output buffer entries; power of two, at least 2.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 resetn  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: one-cycle request to fetch one line; honoured only in IDLE.
REQ-007 base_addr  input  ADDRESS_WIDTH: first byte address of the line; sampled with start.
REQ-008 line_len  input  ADDRESS_WIDTH: number of bytes to fetch; sampled with start.
REQ-009 mem_rd  output  1: read strobe to the memory read port.
REQ-010 mem_addr  output  ADDRESS_WIDTH: read address, valid while mem_rd=1.
REQ-011 mem_din  input  DATA_WIDTH: registered memory output, valid the cycle after mem_rd.
REQ-012 pix_data  output  DATA_WIDTH: head of the output buffer.
REQ-013 pix_valid  output  1: pix_data holds an unconsumed byte.
REQ-014 pix_ready  input  1: consumer accepts; a transfer occurs when pix_valid and pix_ready are both 1.
REQ-015 busy  output  1: high in every state other than IDLE.
REQ-016 done  output  1: one-cycle pulse when the line has completed.
REQ-017 underrun  output  1: one-cycle pulse when pix_ready=1, pix_valid=0 and state is FETCH.

Function
REQ-018 States SHALL be IDLE, FETCH and DRAIN.
REQ-019 IDLE with start=1 and line_len!=0: latch base_addr into the address counter and line_len into the issue and accept counters; go to FETCH.
REQ-020 IDLE with start=1 and line_len=0: pulse done in the next cycle; issue no reads; remain in IDLE.
REQ-021 FETCH: assert mem_rd=1 in a cycle only when issue count is nonzero and (buffered entries + reads in flight) < FIFO_DEPTH.
REQ-022 Each issued read: increment the address counter modulo 2^ADDRESS_WIDTH (0x3FFF wraps to 0x0000) and decrement the issue count.
REQ-023 Read latency: a read issued in cycle N is written into the buffer at the end of N+1; pix_valid is asserted no earlier than N+2.
REQ-024 When the issue count reaches 0, go from FETCH to DRAIN.
REQ-025 DRAIN: issue no reads; remain until the accept count reaches 0.
REQ-026 Decrement the accept count on each transfer.
REQ-027 The final transfer: done=1 in the following cycle, state returns to IDLE, busy=0 from that cycle.
REQ-028 A buffer write and a transfer in the same cycle leave the occupancy unchanged; the buffer never overflows and never outputs stale data.
REQ-029 pix_data SHALL present bytes in address order, one byte per transfer, and hold stable while pix_valid=1 and pix_ready=0.
REQ-030 start in FETCH or DRAIN is ignored; base_addr and line_len changes after the sampling cycle have no effect.
REQ-031 underrun SHALL NOT pulse in IDLE or DRAIN.

Reset
REQ-032 resetn=0 asynchronously forces IDLE, clears counters, empties the buffer, discards in-flight reads, and sets mem_rd, pix_valid, busy, done and underrun to 0; mem_addr and pix_data to 0.
REQ-033 Reset mid-line: after release, no data from the aborted line appears on pix_data and no done is pulsed.

Verification
REQ-034 base_addr=0x0100, line_len=3, pix_ready=1, memory[n]=n[7:0] -> mem_addr 0x0100,0x0101,0x0102 on consecutive cycles; pix_data 0x00,0x01,0x02; first pix_valid two cycles after the first mem_rd; one done pulse.
REQ-035 line_len=10, pix_ready=0 -> exactly 4 reads issued (FIFO_DEPTH=4), mem_rd then low; releasing pix_ready yields all 10 bytes in order with no loss or duplication.
REQ-036 base_addr=0x3FFE, line_len=4 -> mem_addr 0x3FFE,0x3FFF,0x0000,0x0001.
REQ-037 start with line_len=0 -> no mem_rd; done high for one cycle; busy never high.
REQ-038 resetn low after 2 of 8 bytes transferred, then start base 0x0200 len 2 -> only memory[0x200], memory[0x201] appear; done pulses once.
REQ-039 pix_ready toggled randomly, plus start pulses while busy -> ignored starts cause no extra reads; underrun pulses only in FETCH cycles with pix_ready=1, pix_valid=0.
